// File: rtl/serial_transmitter.sv
// UART 8N1 transmitter for the sniffer host link.
// Sends single bytes or masked 32-bit words, LSB first.
module serial_transmitter #(
  parameter int BAUD_DIV = 868
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        writeByte,
  input  logic        writeLong,
  input  logic [31:0] dataIn,
  input  logic [3:0]  disabledGroups,
  output logic        tx,
  output logic        xmit_idle,
  output logic        busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [31:0]   data, data_n;
  logic [3:0]    mask, mask_n;
  logic [7:0]    shift, shift_n;
  logic [1:0]    sel, sel_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [CW-1:0] baud, baud_n;
  logic          tx_n, idle_n;

  logic [1:0] pick;
  logic       found;
  logic [3:0] sel_bit;
  logic       bit_end;
  logic       accept;

  assign sel_bit = 4'b0001 << sel;
  assign bit_end = (baud == '0);
  assign accept  = xmit_idle & (writeByte | writeLong);
  assign busy    = (state == START) | (state == DATA) | (state == STOP);

  // lowest-index byte still pending wins
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!mask[i]) begin
        pick  = 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    data_n    = data;
    mask_n    = mask;
    shift_n   = shift;
    sel_n     = sel;
    bit_cnt_n = bit_cnt;
    baud_n    = baud;
    tx_n      = tx;
    idle_n    = xmit_idle;
    unique case (state)
      IDLE: begin
        idle_n = 1'b1;
        if (accept) begin
          state_n = LOAD;
          data_n  = dataIn;
          mask_n  = writeLong ? disabledGroups : 4'b1110;
          idle_n  = 1'b0;
        end
      end
      LOAD: begin
        if (found) begin
          state_n = START;
          shift_n = data[{pick, 3'b000} +: 8];
          sel_n   = pick;
          tx_n    = 1'b0;
          baud_n  = BAUD_LAST;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          tx_n      = shift[0];
          baud_n    = BAUD_LAST;
          bit_cnt_n = 3'd0;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n    = BAUD_LAST;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          mask_n = mask | sel_bit;
          // nothing left: the empty LOAD is folded into this edge
          state_n = ((mask | sel_bit) == 4'hF) ? IDLE : LOAD;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state     <= IDLE;
      data      <= '0;
      mask      <= '0;
      shift     <= '0;
      sel       <= '0;
      bit_cnt   <= '0;
      baud      <= '0;
      tx        <= 1'b1;
      xmit_idle <= 1'b1;
    end else begin
      state     <= state_n;
      data      <= data_n;
      mask      <= mask_n;
      shift     <= shift_n;
      sel       <= sel_n;
      bit_cnt   <= bit_cnt_n;
      baud      <= baud_n;
      tx        <= tx_n;
      xmit_idle <= idle_n;
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: vector table, hand sequences,
// randomized writes and a bit-sampling UART monitor.
module tb_serial_transmitter;

  localparam int B = 4;
  localparam int FR = 1 + 10 * B;

  logic        clock = 1'b0;
  logic        extReset;
  logic        writeByte;
  logic        writeLong;
  logic [31:0] dataIn;
  logic [3:0]  disabledGroups;
  logic        tx;
  logic        xmit_idle;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  int rx_t[$];

  serial_transmitter #(.BAUD_DIV(B)) dut (
    .clock(clock),
    .extReset(extReset),
    .writeByte(writeByte),
    .writeLong(writeLong),
    .dataIn(dataIn),
    .disabledGroups(disabledGroups),
    .tx(tx),
    .xmit_idle(xmit_idle),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mid-bit sampling receiver; frames overlapping a reset are dropped
  initial begin
    logic [7:0] v;
    logic s, st, bsy, ab;
    int t0;
    forever begin
      @(negedge clock);
      if (extReset === 1'b0 && tx === 1'b0) begin
        t0 = cyc;
        bsy = busy;
        ab = 1'b0;
        @(negedge clock);
        ab |= extReset;
        s = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clock);
          ab |= extReset;
          v[i] = tx;
        end
        repeat (B) @(negedge clock);
        ab |= extReset;
        st = tx;
        if (!ab) begin
          check("frame start/stop/busy", {29'd0, s, st, bsy}, 32'b011);
          rx_q.push_back(v);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    bit to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (xmit_idle) begin
        to = 1'b0;
        break;
      end
    end
    if (to) check({name, " idle timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_write(input string name, input bit b, input bit l,
                           input logic [31:0] d, input logic [3:0] m,
                           input logic [31:0] eb, input int en,
                           input int eidle, input int poke);
    int acc;
    int lowcnt;
    bit to;
    wait_idle(name);
    rx_q.delete();
    rx_t.delete();
    writeByte = b;
    writeLong = l;
    dataIn = d;
    disabledGroups = m;
    @(posedge clock);
    #1;
    acc = cyc;
    writeByte = 1'b0;
    writeLong = 1'b0;
    lowcnt = 0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      writeByte = 1'b0;
      writeLong = 1'b0;
      if (xmit_idle) begin
        to = 1'b0;
        break;
      end
      lowcnt++;
      if (poke != 0 && lowcnt == poke) begin
        writeByte = 1'b1;
        writeLong = 1'b1;
        dataIn = 32'hFFFF_FFFF;
        disabledGroups = 4'h0;
      end
    end
    if (to) check({name, " done timeout"}, 32'd1, 32'd0);
    check({name, " idle_low"}, 32'(lowcnt), 32'(eidle));
    check({name, " busy at idle"}, {31'd0, busy}, 32'd0);
    check({name, " nbytes"}, 32'(rx_q.size()), 32'(en));
    for (int k = 0; k < en && k < rx_q.size(); k++) begin
      check($sformatf("%s byte%0d", name, k), {24'd0, rx_q[k]},
            {24'd0, eb[8*k +: 8]});
      check($sformatf("%s start%0d", name, k), 32'(rx_t[k]),
            32'(acc + 1 + k * FR));
    end
  endtask

  // reference: bytes sent, in order, and xmit_idle low time
  function automatic void model(input bit b, input bit l,
                                input logic [31:0] d, input logic [3:0] m,
                                output logic [31:0] eb, output int en,
                                output int eidle);
    eb = '0;
    en = 0;
    for (int n = 0; n < 4; n++) begin
      if (l ? !m[n] : (n == 0)) begin
        eb[8*en +: 8] = d[8*n +: 8];
        en++;
      end
    end
    eidle = (en == 0) ? 2 : en * FR + 1;
  endfunction

  typedef struct {
    bit          wb;
    bit          wl;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] eb;
    int          en;
    int          eidle;
    int          poke;
  } vec_t;

  vec_t vt[8];
  logic [7:0] tbl[40];

  initial begin
    logic [31:0] eb, d;
    logic [3:0] m;
    int en, eidle;
    bit b, l, bad;

    vt[0] = '{1, 0, 32'h0000_0055, 4'h0, 32'h0000_0055, 1, 42, 0};
    vt[1] = '{1, 0, 32'hAABB_CC12, 4'hF, 32'h0000_0012, 1, 42, 0};
    vt[2] = '{0, 1, 32'hDEAD_BEEF, 4'h0, 32'hDEAD_BEEF, 4, 165, 0};
    vt[3] = '{0, 1, 32'hDEAD_BEEF, 4'h5, 32'h0000_DEBE, 2, 83, 0};
    vt[4] = '{0, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 2, 0};
    vt[5] = '{1, 1, 32'hDEAD_BEEF, 4'h0, 32'hDEAD_BEEF, 4, 165, 0};
    vt[6] = '{1, 0, 32'h0000_0055, 4'h0, 32'h0000_0055, 1, 42, 10};
    vt[7] = '{0, 1, 32'h1234_5678, 4'h8, 32'h0034_5678, 3, 124, 20};

    extReset = 1'b1;
    writeByte = 1'b0;
    writeLong = 1'b0;
    dataIn = '0;
    disabledGroups = '0;
    #1;
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset xmit_idle", {31'd0, xmit_idle}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    extReset = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 8; i++)
      run_write($sformatf("vec%0d", i), vt[i].wb, vt[i].wl, vt[i].d,
                vt[i].m, vt[i].eb, vt[i].en, vt[i].eidle, vt[i].poke);

    // asynchronous reset in the middle of a data bit
    wait_idle("rst");
    rx_q.delete();
    rx_t.delete();
    writeByte = 1'b1;
    dataIn = 32'h0;
    @(posedge clock);
    #1;
    writeByte = 1'b0;
    repeat (12) @(negedge clock);
    check("mid-data tx", {31'd0, tx}, 32'd0);
    #2;
    extReset = 1'b1;
    #1;
    check("async rst tx", {31'd0, tx}, 32'd1);
    check("async rst xmit_idle", {31'd0, xmit_idle}, 32'd1);
    check("async rst busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    extReset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || xmit_idle !== 1'b1) bad = 1'b1;
    end
    check("post-reset line idle", {31'd0, bad}, 32'd0);
    check("post-reset no bytes", 32'(rx_q.size()), 32'd0);

    for (int i = 0; i < 30; i++) begin
      b = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      if (!b && !l) b = 1'b1;
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      model(b, l, d, m, eb, en, eidle);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_write($sformatf("rnd%0d", i), b, l, d, m, eb, en, eidle, 0);
    end

    // upstream handler streaming a table by polling xmit_idle
    for (int i = 0; i < 40; i++) tbl[i] = 8'($urandom);
    wait_idle("stream");
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 40; i++) begin
      wait_idle("stream");
      writeByte = 1'b1;
      dataIn = {24'hA5A5A5, tbl[i]};
      @(posedge clock);
      #1;
      writeByte = 1'b0;
    end
    wait_idle("stream end");
    repeat (2) @(negedge clock);
    check("stream nbytes", 32'(rx_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < rx_q.size(); i++)
      check($sformatf("stream byte%0d", i), {24'd0, rx_q[i]},
            {24'd0, tbl[i]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
